tetris_playfield: RTL and testbench



---
 rtl/tetris_pkg.sv | 34 +++
 rtl/gravity_timer.sv | 30 +++
 rtl/tetris_playfield.sv | 187 ++++++++++++++++++
 tb/tb_tetris_playfield.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared types and helpers for the falling-block playfield.
//   state_t    : playfield controller states
//   LINES_W    : width of the cleared-row counter
//   MAX_CELLS  : largest supported COLS*ROWS for the mask helpers
//   colMask()  : bitmap with every cell of one column set
//   rowMask()  : bitmap with every cell of one row set
package tetris_pkg;

    typedef enum logic [2:0] {
        SPAWN    = 3'd0,
        FALL     = 3'd1,
        LOCK     = 3'd2,
        CLEAR    = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    localparam int LINES_W   = 16;
    localparam int MAX_CELLS = 1024;

    function automatic logic [MAX_CELLS-1:0] colMask(input int cols, input int rows, input int col);
        logic [MAX_CELLS-1:0] m;
        m = '0;
        for (int r = 0; r < rows; r++) m[r*cols + col] = 1'b1;
        return m;
    endfunction

    function automatic logic [MAX_CELLS-1:0] rowMask(input int cols, input int row);
        logic [MAX_CELLS-1:0] m;
        m = '0;
        for (int c = 0; c < cols; c++) m[row*cols + c] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/gravity_timer.sv
// gravity_timer: free-running step counter for piece gravity.
// Counts only while enable is high and is held at zero otherwise, so every
// FALL entry starts a fresh gravity period.
//   clk    in  system clock
//   reset  in  asynchronous, active-high
//   enable in  count while high, clear while low
//   tick   out one-cycle pulse on the last count of each DIV-cycle period
module gravity_timer #(
    parameter int DIV = 25000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              count <= '0;
        else if (!enable)       count <= '0;
        else if (count == LAST) count <= '0;
        else                    count <= count + 1'b1;
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/tetris_playfield.sv
// tetris_playfield: falling-block playfield controller.
// Holds the locked background and the active piece, moves the piece on
// button edges and gravity ticks, locks it on a blocked down-move, and
// respawns or flags game over. Optional row clearing under LINE_CLEAR_EN.
//   clk           in  system clock
//   reset         in  asynchronous, active-high
//   move_left     in  button level, rising edge = one step left
//   move_right    in  button level, rising edge = one step right
//   move_down     in  button level, rising edge = one step down
//   spawn_piece   in  next piece bitmap, sampled in SPAWN
//   background    out locked cells (registered)
//   piece         out active piece cells (registered)
//   lines_cleared out saturating count of cleared rows (0 without LINE_CLEAR_EN)
//   busy          out high in every state except FALL
//   game_over     out high in GAMEOVER
// Build option: define LINE_CLEAR_EN to add the CLEAR state and row counter.
//
// state    | meaning
// SPAWN    | load spawn_piece, or game over if it overlaps the background
// FALL     | piece under user / gravity control
// LOCK     | merge piece into background
// CLEAR    | scan rows bottom-up, collapsing full rows
// GAMEOVER | frozen until reset
module tetris_playfield
    import tetris_pkg::*;
#(
    parameter int COLS        = 12,
    parameter int ROWS        = 12,
    parameter int GRAVITY_DIV = 25000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 move_left,
    input  logic                 move_right,
    input  logic                 move_down,
    input  logic [COLS*ROWS-1:0] spawn_piece,
    output logic [COLS*ROWS-1:0] background,
    output logic [COLS*ROWS-1:0] piece,
    output logic [LINES_W-1:0]   lines_cleared,
    output logic                 busy,
    output logic                 game_over
);
    localparam int N = COLS * ROWS;
    localparam logic [MAX_CELLS-1:0] LEFT_FULL   = colMask(COLS, ROWS, 0);
    localparam logic [MAX_CELLS-1:0] RIGHT_FULL  = colMask(COLS, ROWS, COLS - 1);
    localparam logic [MAX_CELLS-1:0] BOTTOM_FULL = rowMask(COLS, ROWS - 1);
    localparam logic [N-1:0] LEFT_COL   = LEFT_FULL[N-1:0];
    localparam logic [N-1:0] RIGHT_COL  = RIGHT_FULL[N-1:0];
    localparam logic [N-1:0] BOTTOM_ROW = BOTTOM_FULL[N-1:0];

    state_t       state, stateNext;
    logic [N-1:0] pieceNext, bgNext;
    logic         prevLeft, prevRight, prevDown;
    logic         riseLeft, riseRight, riseDown;
    logic         gravTick;
    logic         legalLeft, legalRight, legalDown;

    gravity_timer #(.DIV(GRAVITY_DIV)) uGravity (
        .clk    (clk),
        .reset  (reset),
        .enable (state == FALL),
        .tick   (gravTick)
    );

    // Edge registers track levels in every state, so edges seen while busy
    // are consumed rather than replayed on FALL entry.
    assign riseLeft  = move_left  & ~prevLeft;
    assign riseRight = move_right & ~prevRight;
    assign riseDown  = move_down  & ~prevDown;

    assign legalLeft  = ~|(piece & LEFT_COL)   && ~|((piece >> 1) & background);
    assign legalRight = ~|(piece & RIGHT_COL)  && ~|((piece << 1) & background);
    assign legalDown  = ~|(piece & BOTTOM_ROW) && ~|((piece << COLS) & background);

`ifdef LINE_CLEAR_EN
    localparam int PTR_W = (ROWS > 2) ? $clog2(ROWS) : 1;

    logic [PTR_W-1:0]   rowPtr, rowPtrNext;
    logic [LINES_W-1:0] linesCnt, linesNext;
    logic               rowFull;
    logic [N-1:0]       collapsed;

    assign rowFull = &background[int'(rowPtr)*COLS +: COLS];

    // Rows 1..rowPtr drop by one, row 0 empties, rows below rowPtr stay.
    always_comb begin
        collapsed = background;
        for (int r = 0; r < ROWS; r++) begin
            if (r == 0)                 collapsed[r*COLS +: COLS] = '0;
            else if (r <= int'(rowPtr)) collapsed[r*COLS +: COLS] = background[(r-1)*COLS +: COLS];
        end
    end
`endif

    always_comb begin
        stateNext = state;
        pieceNext = piece;
        bgNext    = background;
`ifdef LINE_CLEAR_EN
        rowPtrNext = rowPtr;
        linesNext  = linesCnt;
`endif
        case (state)
            SPAWN: begin
                if (|(spawn_piece & background)) begin
                    stateNext = GAMEOVER;
                end else begin
                    pieceNext = spawn_piece;
                    stateNext = FALL;
                end
            end
            FALL: begin
                if (riseLeft) begin
                    if (legalLeft) pieceNext = piece >> 1;
                end else if (riseRight) begin
                    if (legalRight) pieceNext = piece << 1;
                end else if (riseDown || gravTick) begin
                    if (legalDown) pieceNext = piece << COLS;
                    else           stateNext = LOCK;
                end
            end
            LOCK: begin
                bgNext    = background | piece;
                pieceNext = '0;
`ifdef LINE_CLEAR_EN
                rowPtrNext = PTR_W'(ROWS - 1);
                stateNext  = CLEAR;
`else
                stateNext  = SPAWN;
`endif
            end
`ifdef LINE_CLEAR_EN
            CLEAR: begin
                // Pointer holds after a collapse: the row dropped into it
                // must be checked too.
                if (rowFull) begin
                    bgNext = collapsed;
                    if (linesCnt != '1) linesNext = linesCnt + 1'b1;
                end else if (rowPtr == '0) begin
                    stateNext = SPAWN;
                end else begin
                    rowPtrNext = rowPtr - 1'b1;
                end
            end
`endif
            GAMEOVER: ;
            default: stateNext = SPAWN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SPAWN;
            piece      <= '0;
            background <= '0;
            prevLeft   <= 1'b0;
            prevRight  <= 1'b0;
            prevDown   <= 1'b0;
        end else begin
            state      <= stateNext;
            piece      <= pieceNext;
            background <= bgNext;
            prevLeft   <= move_left;
            prevRight  <= move_right;
            prevDown   <= move_down;
        end
    end

`ifdef LINE_CLEAR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rowPtr   <= '0;
            linesCnt <= '0;
        end else begin
            rowPtr   <= rowPtrNext;
            linesCnt <= linesNext;
        end
    end
    assign lines_cleared = linesCnt;
`else
    assign lines_cleared = '0;
`endif

    assign busy      = (state != FALL);
    assign game_over = (state == GAMEOVER);

endmodule

// File: tb/tb_tetris_playfield.sv
module tb_tetris_playfield;
    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int DIV  = 4;
    localparam int N    = COLS * ROWS;
`ifdef LINE_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    localparam int M_SPAWN = 0, M_FALL = 1, M_LOCK = 2, M_CLEAR = 3, M_OVER = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ml = 1'b0, mr = 1'b0, md = 1'b0;
    logic [N-1:0]  spawn = '0;
    logic [N-1:0]  background, piece;
    logic [15:0]   lines_cleared;
    logic          busy, game_over;

    int checks = 0;
    int errors = 0;

    tetris_playfield #(.COLS(COLS), .ROWS(ROWS), .GRAVITY_DIV(DIV)) dut (
        .clk           (clk),
        .reset         (reset),
        .move_left     (ml),
        .move_right    (mr),
        .move_down     (md),
        .spawn_piece   (spawn),
        .background    (background),
        .piece         (piece),
        .lines_cleared (lines_cleared),
        .busy          (busy),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (grid of cells) ----------------
    bit mpc [ROWS][COLS];
    bit mbg [ROWS][COLS];
    int mmode, mcnt, mptr, mlines;
    bit mpl, mpr, mpd;

    task automatic modelReset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                mpc[r][c] = 1'b0;
                mbg[r][c] = 1'b0;
            end
        mmode = M_SPAWN; mcnt = 0; mptr = 0; mlines = 0;
        mpl = 0; mpr = 0; mpd = 0;
    endtask

    function automatic logic [N-1:0] gridVec(input bit isPiece);
        logic [N-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[r*COLS + c] = isPiece ? mpc[r][c] : mbg[r][c];
        return v;
    endfunction

    function automatic bit canMove(input int dr, input int dc);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mpc[r][c]) begin
                    if (r + dr < 0 || r + dr >= ROWS || c + dc < 0 || c + dc >= COLS) return 1'b0;
                    if (mbg[r + dr][c + dc]) return 1'b0;
                end
        return 1'b1;
    endfunction

    task automatic movePiece(input int dr, input int dc);
        bit t [ROWS][COLS];
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) t[r][c] = 1'b0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (mpc[r][c]) t[r + dr][c + dc] = 1'b1;
        mpc = t;
    endtask

    task automatic modelStep(input bit lv, input bit rv, input bit dv, input logic [N-1:0] sp);
        bit rl, rr, rd, tick, hit, full;
        int ncnt;
        rl = lv && !mpl; rr = rv && !mpr; rd = dv && !mpd;
        mpl = lv; mpr = rv; mpd = dv;
        tick = (mmode == M_FALL) && (mcnt == DIV - 1);
        ncnt = (mmode == M_FALL) ? (mcnt + 1) % DIV : 0;
        case (mmode)
            M_SPAWN: begin
                hit = 1'b0;
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        if (sp[r*COLS + c] && mbg[r][c]) hit = 1'b1;
                if (hit) mmode = M_OVER;
                else begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++) mpc[r][c] = sp[r*COLS + c];
                    mmode = M_FALL;
                end
            end
            M_FALL: begin
                if (rl) begin
                    if (canMove(0, -1)) movePiece(0, -1);
                end else if (rr) begin
                    if (canMove(0, 1)) movePiece(0, 1);
                end else if (rd || tick) begin
                    if (canMove(1, 0)) movePiece(1, 0);
                    else mmode = M_LOCK;
                end
            end
            M_LOCK: begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) begin
                        mbg[r][c] = mbg[r][c] | mpc[r][c];
                        mpc[r][c] = 1'b0;
                    end
                mptr  = ROWS - 1;
                mmode = CLEAR_EN ? M_CLEAR : M_SPAWN;
            end
            M_CLEAR: begin
                full = 1'b1;
                for (int c = 0; c < COLS; c++) if (!mbg[mptr][c]) full = 1'b0;
                if (full) begin
                    for (int r = mptr; r >= 1; r--)
                        for (int c = 0; c < COLS; c++) mbg[r][c] = mbg[r-1][c];
                    for (int c = 0; c < COLS; c++) mbg[0][c] = 1'b0;
                    if (mlines < 65535) mlines++;
                end else if (mptr == 0) mmode = M_SPAWN;
                else mptr--;
            end
            default: ;
        endcase
        mcnt = ncnt;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic [N-1:0] sp);
        reset = 1'b1;
        ml = 0; mr = 0; md = 0;
        spawn = sp;
        modelReset();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic pressDown();
        md = 1'b1;
        cyc();
        md = 1'b0;
    endtask

    task automatic waitFall(output int n);
        n = 0;
        while (busy && n < 50) begin
            cyc();
            n++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        chk({tag, "_piece"}, piece, 0);
        chk({tag, "_bg"}, background, 0);
        chk({tag, "_lines"}, lines_cleared, 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_gameover"}, game_over, 0);
    endtask

    typedef struct {
        logic         l, r, d;
        logic [N-1:0] expPiece;
        logic [N-1:0] expBg;
        logic         expBusy;
    } vec_t;

    vec_t tbl [12];
    logic [N-1:0] shapes [7] = '{16'h0006, 16'h0003, 16'h0033, 16'h0001, 16'h000F, 16'h0072, 16'h0013};

    initial begin
        int n;
        bit lv, rv, dv;

        // inputs, then expected piece / background / busy after the edge
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0};  // spawn
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0};  // left blocked at col 0
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0006, 16'h0000, 1'b0};  // right
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 16'h0060, 16'h0000, 1'b0};  // gravity tick, 4th FALL cycle
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0};  // left beats right
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0030, 16'h0000, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'h0300, 16'h0000, 1'b0};  // user down
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 1'b0};  // held: gravity only
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 16'h3000, 16'h0000, 1'b1};  // blocked down -> LOCK
        tbl[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h3000, 1'b1};  // locked

        // ---- reset values ----
        reset = 1'b1;
        spawn = 16'h0003;
        #1;
        checkResetValues("reset");
        doReset(16'h0003);
        checkResetValues("reset_release");

        // ---- table-driven single steps ----
        for (int i = 0; i < 12; i++) begin
            ml = tbl[i].l; mr = tbl[i].r; md = tbl[i].d;
            cyc();
            chk($sformatf("tbl%0d_piece", i), piece, tbl[i].expPiece);
            chk($sformatf("tbl%0d_bg", i), background, tbl[i].expBg);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].expBusy);
        end
        ml = 0; mr = 0; md = 0;
        waitFall(n);
        chk("lock_to_fall_cycles", n, CLEAR_EN ? ROWS + 1 : 1);
        chk("respawn_piece", piece, 16'h0003);

        // ---- stack a column, then lock against background ----
        doReset(16'h4000);
        cyc();
        chk("stack_spawn", piece, 16'h4000);
        spawn = 16'h0400; pressDown(); waitFall(n);
        chk("stack2_piece", piece, 16'h0400);
        spawn = 16'h0040; pressDown(); waitFall(n);
        chk("stack3_piece", piece, 16'h0040);
        spawn = 16'h0006; pressDown(); waitFall(n);
        chk("stack4_bg", background, 16'h4440);
        chk("stack4_piece", piece, 16'h0006);
        pressDown();
        chk("bg_block_piece", piece, 16'h0006);
        chk("bg_block_busy", busy, 1);
        cyc();
        chk("bg_lock_bg", background, 16'h4446);
        chk("bg_lock_piece", piece, 16'h0000);

        // ---- game over: respawning 0x0006 now overlaps ----
        n = 0;
        while (!game_over && n < 50) begin
            cyc();
            n++;
        end
        chk("gameover_cycles", n, CLEAR_EN ? ROWS + 1 : 1);
        chk("gameover_flag", game_over, 1);
        chk("gameover_busy", busy, 1);
        spawn = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            ml = i[0]; mr = ~i[0]; md = i[1];
            cyc();
        end
        ml = 0; mr = 0; md = 0;
        chk("frozen_piece", piece, 16'h0000);
        chk("frozen_bg", background, 16'h4446);
        chk("frozen_flag", game_over, 1);
        reset = 1'b1;
        #1;
        chk("gameover_reset_flag", game_over, 0);
        chk("gameover_reset_bg", background, 0);

        // ---- full-row clear ----
        doReset(16'hF100);
        cyc();
        chk("clr_spawn", piece, 16'hF100);
        spawn = 16'h0002;
        pressDown();
        cyc();
        chk("clr_locked_bg", background, 16'hF100);
        waitFall(n);
        chk("clr_cycles", n, CLEAR_EN ? ROWS + 1 + 1 : 1);
        chk("clr_bg", background, CLEAR_EN ? 16'h1000 : 16'hF100);
        chk("clr_lines", lines_cleared, CLEAR_EN ? 1 : 0);
        chk("clr_respawn", piece, 16'h0002);

        // ---- reset mid-CLEAR ----
        doReset(16'hF100);
        cyc();
        pressDown();
        cyc();
        cyc();
        reset = 1'b1;
        #1;
        checkResetValues("midclear_reset");

        // ---- randomized play against the model ----
        doReset(shapes[0]);
        for (int it = 0; it < 2500; it++) begin
            lv = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 3) == 0);
            dv = ($urandom_range(0, 2) == 0);
            ml = lv; mr = rv; md = dv;
            spawn = shapes[$urandom_range(0, 6)];
            modelStep(lv, rv, dv, spawn);
            cyc();
            chk("rnd_piece", piece, gridVec(1'b1));
            chk("rnd_bg", background, gridVec(1'b0));
            chk("rnd_lines", lines_cleared, mlines);
            chk("rnd_busy", busy, mmode != M_FALL);
            chk("rnd_gameover", game_over, mmode == M_OVER);
            if (mmode == M_OVER && $urandom_range(0, 3) == 0) doReset(shapes[$urandom_range(0, 6)]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
